// File: rtl/pr_req_sched.sv
// Round-robin scheduler sharing one DDR-DMA/ICAP reconfiguration path among NUM_REQ requesters.
// Each service: decouple, load addr/len, program ICAP, wait for DMA done or timeout, hold, release.
module pr_req_sched #(
   parameter int unsigned NUM_REQ = 4,
   parameter logic [19:0] TIMEOUT = 20'hFFFFF,
   parameter int unsigned HOLD    = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [NUM_REQ-1:0] o_done,
   output logic               o_err,
   input  logic               i_tbl_wr_en,
   input  logic [2:0]         i_tbl_wr_idx,
   input  logic [26:0]        i_tbl_wr_addr,
   input  logic [19:0]        i_tbl_wr_len,
   output logic [26:0]        o_ddr_strt_addr,
   output logic [19:0]        o_trans_len,
   output logic               o_load,
   output logic               o_pgrm_icap,
   input  logic               i_dma_done,
   output logic               o_pr_reset,
   output logic [19:0]        o_icap_clk_cnt,
   output logic [19:0]        o_total_clk_cnt,
   output logic               o_busy
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned HoldW = $clog2(HOLD + 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);
   localparam logic [19:0] CntMax = 20'hFFFFF;

   typedef enum logic [2:0] {StIdle, StLoad, StPgm, StWait, StRelease, StDone} state_e;

   state_e              r_state;
   logic [26:0]         r_tbl_addr [NUM_REQ];
   logic [19:0]         r_tbl_len  [NUM_REQ];
   logic [IdxW-1:0]     r_last;
   logic [IdxW-1:0]     r_gidx;
   logic [HoldW-1:0]    r_hold;
   logic [19:0]         r_icap;
   logic [19:0]         r_total;
   logic                r_err;

   logic                w_any;
   logic [IdxW-1:0]     w_pick;
   logic [IdxW-1:0]     w_cand;
   logic [NUM_REQ-1:0]  w_onehot;
   logic [19:0]         w_icap_inc;
   logic [19:0]         w_total_inc;

   // Scan from farthest to nearest so the first set bit after r_last wins.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_cand = '0;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         w_cand = IdxW'((32'(r_last) + k) % NUM_REQ);
         if (i_req[w_cand]) begin
            w_any  = 1'b1;
            w_pick = w_cand;
         end
      end
      w_onehot = '0;
      w_onehot[w_pick] = 1'b1;
   end

   assign w_icap_inc  = (r_icap == CntMax) ? r_icap : r_icap + 20'd1;
   assign w_total_inc = (r_total == CntMax) ? r_total : r_total + 20'd1;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state         <= StIdle;
         r_last          <= IdxW'(NUM_REQ - 1);
         r_gidx          <= '0;
         r_hold          <= '0;
         r_icap          <= '0;
         r_total         <= '0;
         r_err           <= 1'b0;
         o_grant         <= '0;
         o_done          <= '0;
         o_err           <= 1'b0;
         o_ddr_strt_addr <= '0;
         o_trans_len     <= '0;
         o_load          <= 1'b0;
         o_pgrm_icap     <= 1'b0;
         o_pr_reset      <= 1'b0;
         o_icap_clk_cnt  <= '0;
         o_total_clk_cnt <= '0;
         o_busy          <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_tbl_addr[i] <= '0;
            r_tbl_len[i]  <= '0;
         end
      end else begin
         o_load      <= 1'b0;
         o_pgrm_icap <= 1'b0;
         o_done      <= '0;
         o_err       <= 1'b0;

         // Capture reads the pre-write table value when a write lands on the same edge.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i_tbl_wr_en && i_tbl_wr_idx == 3'(i)) begin
               r_tbl_addr[i] <= i_tbl_wr_addr;
               r_tbl_len[i]  <= i_tbl_wr_len;
            end
         end

         if (r_state != StIdle) begin
            r_total <= w_total_inc;
         end

         case (r_state)
            StIdle: begin
               if (w_any) begin
                  r_state         <= StLoad;
                  r_gidx          <= w_pick;
                  o_grant         <= w_onehot;
                  o_pr_reset      <= 1'b1;
                  o_busy          <= 1'b1;
                  r_total         <= 20'd1;
                  r_icap          <= '0;
                  r_err           <= 1'b0;
                  o_ddr_strt_addr <= r_tbl_addr[w_pick];
                  o_trans_len     <= r_tbl_len[w_pick];
               end
            end
            StLoad: begin
               o_load <= 1'b1;
               if (o_trans_len == 20'd0) begin
                  r_err   <= 1'b1;
                  r_hold  <= '0;
                  r_state <= StRelease;
               end else begin
                  r_state <= StPgm;
               end
            end
            StPgm: begin
               o_pgrm_icap <= 1'b1;
               r_icap      <= '0;
               r_state     <= StWait;
            end
            StWait: begin
               r_icap <= w_icap_inc;
               if (i_dma_done) begin
                  r_err   <= 1'b0;
                  r_hold  <= '0;
                  r_state <= StRelease;
               end else if (w_icap_inc >= TIMEOUT) begin
                  r_err   <= 1'b1;
                  r_hold  <= '0;
                  r_state <= StRelease;
               end
            end
            StRelease: begin
               if (r_hold == HoldLast) begin
                  o_pr_reset      <= 1'b0;
                  o_done          <= o_grant;
                  o_err           <= r_err;
                  o_icap_clk_cnt  <= r_icap;
                  o_total_clk_cnt <= r_total;
                  r_state         <= StDone;
               end else begin
                  r_hold <= r_hold + HoldW'(1);
               end
            end
            StDone: begin
               o_grant         <= '0;
               o_busy          <= 1'b0;
               o_ddr_strt_addr <= '0;
               o_trans_len     <= '0;
               r_last          <= r_gidx;
               r_state         <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
